tlb_data_xlate: RTL and testbench

- Data-side address translation stage between the memory-stage address generator and the data cache / bus interface.
- Drives the data-lookup inputs of the TLB line array: VPN, unmapped flag, load/store qualifier.
- Consumes the array's hit, PFN-pair, valid-pair and dirty-pair outputs. Registers the physical address, cacheability and any TLB or address exception into a one-entry output stage with valid/ready handshake.

---
 rtl/tlb_data_xlate_if.sv | 36 +++
 rtl/tlb_data_xlate.sv | 150 +++++++++++++++
 tb/tb_tlb_data_xlate.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_data_xlate_if.sv
// Request/response bus between the memory-stage address generator, the
// data translation stage and the data cache / bus interface.
interface tlb_data_xlate_if #(
    parameter int unsigned PA_W = 32
);
    // Request side: virtual address from the memory stage
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_vaddr;
    logic            req_store;
    logic [1:0]      req_size;

    // Response side: translated address or exception
    logic            resp_valid;
    logic            resp_ready;
    logic [PA_W-1:0] resp_paddr;
    logic            resp_uncached;
    logic            resp_exc;
    logic [4:0]      resp_exc_code;
    logic            resp_refill;
    logic [31:0]     resp_badvaddr;

    // Requester / response consumer
    modport master (
        output req_valid, req_vaddr, req_store, req_size, resp_ready,
        input  req_ready, resp_valid, resp_paddr, resp_uncached, resp_exc,
               resp_exc_code, resp_refill, resp_badvaddr
    );

    // Translation stage
    modport slave (
        input  req_valid, req_vaddr, req_store, req_size, resp_ready,
        output req_ready, resp_valid, resp_paddr, resp_uncached, resp_exc,
               resp_exc_code, resp_refill, resp_badvaddr
    );
endinterface

// File: rtl/tlb_data_xlate.sv
// Data-side address translation stage: segment decode, TLB lookup on the
// data port of the line array, exception prioritisation and a one-entry
// registered response stage with valid/ready handshake.
module tlb_data_xlate #(
    parameter int unsigned VPN_W = 19,
    parameter int unsigned PFN_W = 24,
    parameter int unsigned PA_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    tlb_data_xlate_if.slave      bus,
    output logic [VPN_W-1:0]     tlb_vpn_o,
    output logic                 tlb_unmapped_o,
    output logic                 tlb_load_store_o,
    input  logic                 tlb_hit_i,
    input  logic [2*PFN_W-1:0]   tlb_pfn_i,
    input  logic [1:0]           tlb_v_i,
    input  logic [1:0]           tlb_d_i,
    output logic [31:0]          miss_count_o
);

    localparam int unsigned PG_W  = 12;
    localparam int unsigned CNT_W = 32;

    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef struct packed {
        logic [PA_W-1:0] paddr;
        logic            uncached;
        logic            exc;
        logic [4:0]      exc_code;
        logic            refill;
        logic [31:0]     badvaddr;
    } resp_t;

    resp_t              resp_q, resp_d, lookup;
    logic               resp_valid_q, resp_valid_d;
    logic [CNT_W-1:0]   miss_q, miss_d;

    logic               accept;
    logic               kseg0, kseg1, unmapped;
    logic               page_sel;
    logic [PFN_W-1:0]   pfn_sel;
    logic               v_sel, d_sel;
    logic               misaligned;
    logic               lookup_miss;
    logic               unused_pfn_hi;

    // Handshake: one-entry stage, accept whenever it is empty or draining
    assign bus.req_ready = ~flush_i & (~resp_valid_q | bus.resp_ready);
    assign accept        = bus.req_valid & bus.req_ready;

    // TLB data-port drive
    assign tlb_vpn_o        = bus.req_vaddr[31:31-VPN_W+1];
    assign tlb_unmapped_o   = unmapped;
    assign tlb_load_store_o = accept;

    // Segment decode, page-pair select and exception prioritisation
    always_comb begin
        kseg0       = (bus.req_vaddr[31:29] == 3'b100);
        kseg1       = (bus.req_vaddr[31:29] == 3'b101);
        unmapped    = kseg0 | kseg1;
        page_sel    = bus.req_vaddr[PG_W];
        pfn_sel     = page_sel ? tlb_pfn_i[2*PFN_W-1:PFN_W] : tlb_pfn_i[PFN_W-1:0];
        v_sel       = page_sel ? tlb_v_i[1] : tlb_v_i[0];
        d_sel       = page_sel ? tlb_d_i[1] : tlb_d_i[0];
        lookup_miss = 1'b0;

        // Size 3 falls into the word case
        case (bus.req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = bus.req_vaddr[0];
            default: misaligned = |bus.req_vaddr[1:0];
        endcase

        lookup          = '0;
        lookup.badvaddr = bus.req_vaddr;
        lookup.uncached = kseg1;
        if (unmapped) begin
            lookup.paddr = PA_W'(bus.req_vaddr & 32'h1FFF_FFFF);
        end else begin
            lookup.paddr = {pfn_sel[PA_W-PG_W-1:0], bus.req_vaddr[PG_W-1:0]};
        end

        if (misaligned) begin
            lookup.exc      = 1'b1;
            lookup.exc_code = bus.req_store ? EXC_ADES : EXC_ADEL;
        end else if (!unmapped && !tlb_hit_i) begin
            lookup.exc      = 1'b1;
            lookup.exc_code = bus.req_store ? EXC_TLBS : EXC_TLBL;
            lookup.refill   = 1'b1;
            lookup_miss     = 1'b1;
        end else if (!unmapped && !v_sel) begin
            lookup.exc      = 1'b1;
            lookup.exc_code = bus.req_store ? EXC_TLBS : EXC_TLBL;
        end else if (!unmapped && bus.req_store && !d_sel) begin
            lookup.exc      = 1'b1;
            lookup.exc_code = EXC_MOD;
        end
    end

    // PFN bits above the physical address range are not used
    assign unused_pfn_hi = ^pfn_sel[PFN_W-1:PA_W-PG_W];

    // Response stage and refill counter next state
    always_comb begin
        resp_d       = resp_q;
        resp_valid_d = resp_valid_q;
        miss_d       = miss_q;
        if (accept) begin
            resp_d       = lookup;
            resp_valid_d = 1'b1;
            if (lookup_miss && (miss_q != {CNT_W{1'b1}})) begin
                miss_d = miss_q + CNT_W'(1);
            end
        end else if (flush_i) begin
            resp_valid_d = 1'b0;
        end else if (resp_valid_q && bus.resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            miss_q       <= '0;
        end else begin
            resp_q       <= resp_d;
            resp_valid_q <= resp_valid_d;
            miss_q       <= miss_d;
        end
    end

    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_paddr    = resp_q.paddr;
    assign bus.resp_uncached = resp_q.uncached;
    assign bus.resp_exc      = resp_q.exc;
    assign bus.resp_exc_code = resp_q.exc_code;
    assign bus.resp_refill   = resp_q.refill;
    assign bus.resp_badvaddr = resp_q.badvaddr;
    assign miss_count_o      = miss_q;

endmodule

// File: tb/tb_tlb_data_xlate.sv
// Scoreboard bench for tlb_data_xlate: expected responses are queued at
// accept time and compared when the consumer takes them.
module tb_tlb_data_xlate;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [18:0] tlb_vpn;
    logic        tlb_unmapped;
    logic        tlb_load_store;
    logic        tlb_hit = 1'b0;
    logic [47:0] tlb_pfn = '0;
    logic [1:0]  tlb_v = '0;
    logic [1:0]  tlb_d = '0;
    logic [31:0] miss_count;

    tlb_data_xlate_if #(.PA_W(32)) bus ();

    tlb_data_xlate #(.VPN_W(19), .PFN_W(24), .PA_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush),
        .bus              (bus),
        .tlb_vpn_o        (tlb_vpn),
        .tlb_unmapped_o   (tlb_unmapped),
        .tlb_load_store_o (tlb_load_store),
        .tlb_hit_i        (tlb_hit),
        .tlb_pfn_i        (tlb_pfn),
        .tlb_v_i          (tlb_v),
        .tlb_d_i          (tlb_d),
        .miss_count_o     (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] paddr;
        logic        unc;
        logic        exc;
        logic [4:0]  code;
        logic        refill;
        logic [31:0] bad;
        logic [31:0] mc;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference translation from the architectural rules
    function automatic exp_t model(input logic [31:0] va, input logic st, input logic [1:0] sz,
                                   input logic hit, input logic [47:0] pfn,
                                   input logic [1:0] v, input logic [1:0] d);
        exp_t        e;
        logic        mapped;
        logic [23:0] pg;
        logic        pv, pd, align_bad;
        mapped    = (va[31:29] != 3'b100) && (va[31:29] != 3'b101);
        pg        = va[12] ? pfn[47:24] : pfn[23:0];
        pv        = va[12] ? v[1] : v[0];
        pd        = va[12] ? d[1] : d[0];
        align_bad = (sz == 2'd1 && va[0]) || (sz[1] && va[1:0] != 2'b00);
        e.bad     = va;
        e.unc     = (va[31:29] == 3'b101);
        e.paddr   = mapped ? {pg[19:0], va[11:0]} : {3'b000, va[28:0]};
        e.exc     = 1'b1;
        e.refill  = 1'b0;
        if (align_bad)             e.code = st ? 5'd5 : 5'd4;
        else if (mapped && !hit) begin
            e.code   = st ? 5'd3 : 5'd2;
            e.refill = 1'b1;
        end
        else if (mapped && !pv)    e.code = st ? 5'd3 : 5'd2;
        else if (mapped && st && !pd) e.code = 5'd1;
        else begin
            e.exc  = 1'b0;
            e.code = 5'd0;
        end
        e.mc = 0;
        return e;
    endfunction

    // Drive one request from a negedge; returns at the negedge after accept
    task automatic send(input logic [31:0] va, input logic st, input logic [1:0] sz,
                        input logic hit, input logic [47:0] pfn,
                        input logic [1:0] v, input logic [1:0] d);
        exp_t e;
        bit   done = 0;
        bus.req_valid = 1'b1;
        bus.req_vaddr = va;
        bus.req_store = st;
        bus.req_size  = sz;
        tlb_hit = hit;
        tlb_pfn = pfn;
        tlb_v   = v;
        tlb_d   = d;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (bus.req_ready) begin
                chk("tlb_vpn", 32'(tlb_vpn), 32'(va[31:13]));
                chk("tlb_unmapped", 32'(tlb_unmapped), 32'(va[31:30] == 2'b10 && va[29:29] !== 1'bx));
                chk("tlb_load_store", 32'(tlb_load_store), 32'd1);
                e = model(va, st, sz, hit, pfn, v, d);
                if (e.refill) exp_miss = exp_miss + 1;
                e.mc = exp_miss;
                sb.push_back(e);
                @(posedge clk);
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_left", 32'(sb.size()), 32'd0);
        @(negedge clk);
        #3 chk("idle_valid", 32'(bus.resp_valid), 32'd0);
    endtask

    // Response monitor: compare at each completed handshake
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst && bus.resp_valid && bus.resp_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_resp", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                if (!e.exc) chk("paddr", bus.resp_paddr, e.paddr);
                chk("uncached", 32'(bus.resp_uncached), 32'(e.unc));
                chk("exc", 32'(bus.resp_exc), 32'(e.exc));
                chk("exc_code", 32'(bus.resp_exc_code), 32'(e.code));
                chk("refill", 32'(bus.resp_refill), 32'(e.refill));
                chk("badvaddr", bus.resp_badvaddr, e.bad);
                chk("miss_count", miss_count, e.mc);
            end
        end
    end

    logic [31:0] held_pa;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_vaddr  = '0;
        bus.req_store  = 1'b0;
        bus.req_size   = 2'd2;
        bus.resp_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_paddr", bus.resp_paddr, 32'd0);
        chk("rst_code", 32'(bus.resp_exc_code), 32'd0);
        chk("rst_bad", bus.resp_badvaddr, 32'd0);
        chk("rst_mc", miss_count, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Unmapped segments
        send(32'h8000_1234, 0, 2'd2, 0, '0, 2'b00, 2'b00);
        send(32'hA000_0010, 0, 2'd2, 0, '0, 2'b00, 2'b00);
        // Mapped hits, odd and even page
        send(32'h0040_3008, 0, 2'd2, 1, {24'h000ABC, 24'h0}, 2'b10, 2'b00);
        send(32'h0040_2008, 0, 2'd2, 1, {24'h0, 24'h000123}, 2'b01, 2'b00);
        drain();
        chk("mc_zero", miss_count, 32'd0);

        // Refill misses
        send(32'h0040_0000, 0, 2'd2, 0, '0, 2'b11, 2'b11);
        drain();
        chk("mc_one", miss_count, 32'd1);
        send(32'h0040_0000, 1, 2'd2, 0, '0, 2'b11, 2'b11);
        // Invalid page, modified, misaligned over a miss, size 3, byte odd
        send(32'h0040_0004, 0, 2'd2, 1, {24'h0, 24'h000777}, 2'b10, 2'b11);
        send(32'h0040_0004, 1, 2'd2, 1, {24'h0, 24'h000777}, 2'b10, 2'b11);
        send(32'h0040_0004, 1, 2'd2, 1, {24'h0, 24'h000777}, 2'b01, 2'b10);
        send(32'h0040_0001, 1, 2'd1, 0, '0, 2'b00, 2'b00);
        send(32'h8000_0002, 0, 2'd3, 0, '0, 2'b00, 2'b00);
        send(32'h8000_0003, 1, 2'd0, 0, '0, 2'b00, 2'b00);
        send(32'h0040_1006, 1, 2'd1, 1, {24'hFFF456, 24'h0}, 2'b10, 2'b10);
        drain();
        chk("mc_two", miss_count, 32'd2);

        // Backpressure with back-to-back requests
        bus.resp_ready = 1'b0;
        send(32'h0040_3010, 0, 2'd2, 1, {24'h000111, 24'h0}, 2'b10, 2'b00);
        fork
            send(32'hA000_0100, 1, 2'd2, 0, '0, 2'b00, 2'b00);
            begin
                #2;
                chk("bp_ready_low", 32'(bus.req_ready), 32'd0);
                chk("bp_valid", 32'(bus.resp_valid), 32'd1);
                held_pa = bus.resp_paddr;
                @(negedge clk);
                #2 chk("bp_stable", bus.resp_paddr, held_pa);
                chk("bp_ready_low2", 32'(bus.req_ready), 32'd0);
                @(negedge clk);
                bus.resp_ready = 1'b1;
            end
        join
        drain();

        // Flush kills the held response and blocks accept
        bus.resp_ready = 1'b0;
        send(32'h8000_0040, 0, 2'd2, 0, '0, 2'b00, 2'b00);
        flush = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_vaddr = 32'h0050_0000;
        tlb_hit = 1'b0;
        #1 chk("flush_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.req_valid = 1'b0;
        chk("flush_valid", 32'(bus.resp_valid), 32'd0);
        chk("flush_mc", miss_count, exp_miss);
        void'(sb.pop_front());
        bus.resp_ready = 1'b1;
        @(negedge clk);
        drain();

        // Reset mid-stream
        bus.resp_ready = 1'b0;
        send(32'h0060_0000, 1, 2'd2, 0, '0, 2'b00, 2'b00);
        chk("pre_rst_mc", miss_count, 32'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_valid", 32'(bus.resp_valid), 32'd0);
        chk("mrst_exc", 32'(bus.resp_exc), 32'd0);
        chk("mrst_code", 32'(bus.resp_exc_code), 32'd0);
        chk("mrst_refill", 32'(bus.resp_refill), 32'd0);
        chk("mrst_bad", bus.resp_badvaddr, 32'd0);
        chk("mrst_mc", miss_count, 32'd0);
        sb.delete();
        exp_miss = 0;
        @(negedge clk);
        rst = 1'b0;
        bus.resp_ready = 1'b1;
        send(32'h8000_0ABC, 0, 2'd0, 0, '0, 2'b00, 2'b00);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
